// File: rtl/pc_pkg.sv
// ============================================================================
// Module   : pc_pkg
// Brief    : Shared encodings, default vectors and trap-cause type for pc_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_J   = 2'd2;
  localparam logic [1:0] PC_JR  = 2'd3;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] DEF_IRQ_VEC   = 32'h8000_0008;

  typedef enum logic [2:0] {
    TRAP_NONE   = 3'd0,
    TRAP_ILLOP  = 3'd1,
    TRAP_IRQ    = 3'd2,
    TRAP_ERET   = 3'd3,
    TRAP_AFAULT = 3'd4
  } trap_cause_e;

endpackage

`default_nettype wire

// File: rtl/pc_trap_arb.sv
// ============================================================================
// Module   : pc_trap_arb
// Brief    : Combinational priority arbiter: illop > misalign > irq > eret.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_trap_arb
  import pc_pkg::*;
(
  input  logic        stall_i,
  input  logic        illop_i,
  input  logic        eret_i,
  input  logic        irq_pend_i,
  input  logic        kernel_i,
  input  logic        misalign_i,
  output trap_cause_e cause_o
);

  always_comb begin
    cause_o = TRAP_NONE;
    if (stall_i) begin
      cause_o = TRAP_NONE;
    end else if (illop_i || (eret_i && !kernel_i)) begin
      // A user-mode eret is privileged and faults like an illegal op.
      cause_o = TRAP_ILLOP;
    end else if (misalign_i) begin
      cause_o = TRAP_AFAULT;
    end else if (irq_pend_i && !kernel_i) begin
      cause_o = TRAP_IRQ;
    end else if (eret_i) begin
      cause_o = TRAP_ERET;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Brief    : PC register, next-PC mux, EPC and sticky IRQ latch for the MIPS core.
//            Optional PC_ALIGN_CHECK_EN: misaligned jr/eret targets fault.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              KBIT      = 31,
  parameter logic [XLEN-1:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [XLEN-1:0] ILLOP_VEC = DEF_ILLOP_VEC,
  parameter logic [XLEN-1:0] IRQ_VEC   = DEF_IRQ_VEC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic [1:0]      pc_src_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_offset_i,
  input  logic [25:0]     jtarget_i,
  input  logic [XLEN-1:0] jr_target_i,
  input  logic            illop_i,
  input  logic            irq_i,
  input  logic            eret_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] epc_o,
  output logic            kernel_o,
  output logic            trap_irq_o,
  output logic            trap_illop_o,
  output logic            addr_fault_o
);

  localparam logic [XLEN-1:0] KBIT_CLR   = ~(XLEN'(1) << KBIT);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            irq_pend_q, irq_pend_d;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jr_tgt;
  logic [XLEN-1:0] eret_tgt;
  logic [XLEN-1:0] flow_tgt;
  logic            kernel;
  logic            misalign;
  trap_cause_e     cause;

  assign pc_plus4 = pc_q + XLEN'(4);
  assign kernel   = pc_q[KBIT];

  // User-mode jr cannot reach kernel space; eret always returns to user space.
  always_comb begin
    jr_tgt = kernel ? jr_target_i : (jr_target_i & KBIT_CLR);
    eret_tgt = epc_q & KBIT_CLR;
`ifndef PC_ALIGN_CHECK_EN
    jr_tgt   = jr_tgt & ALIGN_MASK;
    eret_tgt = eret_tgt & ALIGN_MASK;
`endif
  end

`ifdef PC_ALIGN_CHECK_EN
  assign misalign = (eret_i && kernel) ? (|epc_q[1:0])
                                       : ((pc_src_i == PC_JR) && (|jr_target_i[1:0]));
`else
  assign misalign = 1'b0;
`endif

  pc_trap_arb u_arb (
    .stall_i    (stall_i),
    .illop_i    (illop_i),
    .eret_i     (eret_i),
    .irq_pend_i (irq_pend_q),
    .kernel_i   (kernel),
    .misalign_i (misalign),
    .cause_o    (cause)
  );

  always_comb begin
    flow_tgt = pc_plus4;
    unique case (pc_src_i)
      PC_BR:   flow_tgt = br_taken_i ? (pc_plus4 + (br_offset_i << 2)) : pc_plus4;
      PC_J:    flow_tgt = {pc_plus4[XLEN-1:28], jtarget_i, 2'b00};
      PC_JR:   flow_tgt = jr_tgt;
      default: flow_tgt = pc_plus4;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    irq_pend_d = irq_pend_q | irq_i;
    unique case (cause)
      TRAP_ILLOP: begin
        pc_d = ILLOP_VEC;
        if (!kernel) epc_d = pc_plus4;
      end
      TRAP_AFAULT: begin
        pc_d = ILLOP_VEC;
        if (!kernel) epc_d = pc_q;
      end
      TRAP_IRQ: begin
        pc_d       = IRQ_VEC;
        epc_d      = pc_q;
        irq_pend_d = 1'b0;
      end
      TRAP_ERET: pc_d = eret_tgt;
      default:   if (!stall_i) pc_d = flow_tgt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_VEC;
      epc_q      <= '0;
      irq_pend_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign pc_o         = pc_q;
  assign pc_plus4_o   = pc_plus4;
  assign epc_o        = epc_q;
  assign kernel_o     = kernel;
  assign trap_irq_o   = (cause == TRAP_IRQ);
  assign trap_illop_o = (cause == TRAP_ILLOP) || (cause == TRAP_AFAULT);
`ifdef PC_ALIGN_CHECK_EN
  assign addr_fault_o = (cause == TRAP_AFAULT);
`else
  assign addr_fault_o = 1'b0;
`endif

endmodule

`default_nettype wire
